// File: rtl/axi_lite_master_if_pkg.sv
// Shared types for the AXI4-Lite initiator: response codes, FSM states, width defaults.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } mst_state_t;

  // Anything other than OKAY counts as an error response (EXOKAY is meaningless on AXI-Lite).
  function automatic logic resp_is_err(input logic [1:0] code);
    return resp_t'(code) != OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_master_if_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite initiator: one command in, one AXI-Lite transaction out, one response back.
// Define AXIL_MST_ERRCNT_EN to add err_cnt, a saturating count of non-OKAY B/R responses.
module axi_lite_master_if
  import axil_pkg::*;
#(
  parameter int ADDR_W = AXIL_ADDR_W,
  parameter int DATA_W = AXIL_DATA_W   // 32 or 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_is_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
`ifdef AXIL_MST_ERRCNT_EN
  output logic [15:0]         err_cnt,
`endif
  axil_if.master              m_axi
);

  localparam int STRB_W = DATA_W / 8;

  mst_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              rsp_is_write_q, rsp_is_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;

  logic cmd_hs, aw_hs, w_hs, b_hs, r_hs, ar_hs;

  // Handshakes are qualified by state, never by the ready alone.
  always_comb begin
    cmd_hs = (state_q == IDLE) && cmd_valid;
    aw_hs  = (state_q == WR_REQ) && !aw_done_q && m_axi.awready;
    w_hs   = (state_q == WR_REQ) && !w_done_q && m_axi.wready;
    b_hs   = (state_q == WR_RESP) && m_axi.bvalid;
    ar_hs  = (state_q == RD_ADDR) && m_axi.arready;
    r_hs   = (state_q == RD_DATA) && m_axi.rvalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      rsp_is_write_q <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_resp_q     <= 2'b00;
    end else begin
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      rsp_is_write_q <= rsp_is_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_resp_q     <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    rsp_is_write_d = rsp_is_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_resp_d     = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d         = cmd_addr;
          wdata_d        = cmd_wdata;
          wstrb_d        = cmd_wstrb;
          aw_done_d      = 1'b0;
          w_done_d       = 1'b0;
          rsp_is_write_d = cmd_write;
          state_d        = cmd_write ? WR_REQ : RD_ADDR;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; either order or the same cycle is fine.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          rsp_resp_d  = m_axi.bresp;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          rsp_resp_d  = m_axi.rresp;
          rsp_rdata_d = m_axi.rdata;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All valids and readies decode from registered state so reset clears them immediately.
  always_comb begin
    cmd_ready     = (state_q == IDLE) && !rst;
    busy          = (state_q != IDLE);
    rsp_valid     = (state_q == RSP);
    rsp_is_write  = rsp_is_write_q;
    rsp_rdata     = rsp_rdata_q;
    rsp_resp      = rsp_resp_q;

    m_axi.awaddr  = addr_q;
    m_axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
    m_axi.wdata   = wdata_q;
    m_axi.wstrb   = wstrb_q;
    m_axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
    m_axi.bready  = (state_q == WR_RESP);
    m_axi.araddr  = addr_q;
    m_axi.arvalid = (state_q == RD_ADDR);
    m_axi.rready  = (state_q == RD_DATA);
  end

`ifdef AXIL_MST_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (((b_hs && resp_is_err(m_axi.bresp)) || (r_hs && resp_is_err(m_axi.rresp)))
        && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_lite_master_if.sv
// Self-checking bench for axi_lite_master_if: behavioural 4-register slave, reference model, protocol monitor.
module tb_axi_lite_master_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_is_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
`ifdef AXIL_MST_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  axil_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi_lite_master_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_is_write (rsp_is_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .busy         (busy),
`ifdef AXIL_MST_ERRCNT_EN
    .err_cnt      (err_cnt),
`endif
    .m_axi        (axi)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural slave: 4 regs at 0x0..0xC ----------------
  // mode 0: always ready, 1: random readies/latency, 2: awready 3 cycles after W, 3: never ready
  int          mode = 0;
  logic [31:0] s_mem [4];
  bit          aw_have, w_have, ar_have, b_pend;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  logic [1:0]  b_code;
  int          w_wait, b_wait, r_wait;

  always @(posedge clk) begin
    if (rst) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.arready <= 1'b0;
      axi.bvalid  <= 1'b0; axi.bresp  <= 2'b00;
      axi.rvalid  <= 1'b0; axi.rresp  <= 2'b00; axi.rdata <= '0;
      aw_have = 0; w_have = 0; ar_have = 0; b_pend = 0;
      w_wait = 0; b_wait = 0; r_wait = 0;
      for (int k = 0; k < 4; k++) s_mem[k] = '0;
    end else begin
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (axi.awvalid && axi.awready) begin aw_have = 1; aw_a = axi.awaddr; end
      if (axi.wvalid && axi.wready) begin
        w_have = 1; w_d = axi.wdata; w_s = axi.wstrb; w_wait = 3;
      end
      if (axi.arvalid && axi.arready) begin
        ar_have = 1; ar_a = axi.araddr; r_wait = (mode == 1) ? $urandom_range(0, 3) : 0;
      end
      if (aw_have && w_have) begin
        aw_have = 0; w_have = 0; b_pend = 1;
        b_wait = (mode == 2) ? 1 : (mode == 1) ? $urandom_range(0, 3) : 0;
        if (aw_a < 32'h10) begin
          for (int b = 0; b < 4; b++)
            if (w_s[b]) s_mem[aw_a[3:2]][8*b +: 8] = w_d[8*b +: 8];
          b_code = 2'b00;
        end else begin
          b_code = 2'b10;
        end
      end
      if (b_pend) begin
        if (b_wait == 0) begin axi.bvalid <= 1'b1; axi.bresp <= b_code; b_pend = 0; end
        else b_wait--;
      end
      if (ar_have) begin
        if (r_wait == 0) begin
          axi.rvalid <= 1'b1;
          axi.rdata  <= (ar_a < 32'h10) ? s_mem[ar_a[3:2]] : 32'hDEAD_BEEF;
          axi.rresp  <= (ar_a < 32'h10) ? 2'b00 : 2'b11;
          ar_have = 0;
        end else r_wait--;
      end
      if (w_have && w_wait > 0) w_wait--;
      case (mode)
        0: begin axi.awready <= 1'b1; axi.wready <= 1'b1; axi.arready <= 1'b1; end
        1: begin
          axi.awready <= 1'($urandom_range(0, 1));
          axi.wready  <= 1'($urandom_range(0, 1));
          axi.arready <= 1'($urandom_range(0, 1));
        end
        2: begin axi.awready <= w_have && (w_wait == 0); axi.wready <= 1'b1; axi.arready <= 1'b1; end
        default: begin axi.awready <= 1'b0; axi.wready <= 1'b0; axi.arready <= 1'b0; end
      endcase
    end
  end

  // ---------------- protocol monitor: pending valids must hold with stable payload ----------------
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awa, p_wd, p_ara;
  logic [3:0]  p_ws;

  always @(negedge clk) begin
    if (rst) begin
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    end else begin
      if (p_awv && !p_awr) begin
        tests++;
        assert (axi.awvalid === 1'b1 && axi.awaddr === p_awa) else begin
          fails++;
          $error("FAIL aw_stable: observed v=%b a=%h expected v=1 a=%h", axi.awvalid, axi.awaddr, p_awa);
        end
      end
      if (p_wv && !p_wr) begin
        tests++;
        assert (axi.wvalid === 1'b1 && axi.wdata === p_wd && axi.wstrb === p_ws) else begin
          fails++;
          $error("FAIL w_stable: observed v=%b d=%h s=%h expected v=1 d=%h s=%h",
                 axi.wvalid, axi.wdata, axi.wstrb, p_wd, p_ws);
        end
      end
      if (p_arv && !p_arr) begin
        tests++;
        assert (axi.arvalid === 1'b1 && axi.araddr === p_ara) else begin
          fails++;
          $error("FAIL ar_stable: observed v=%b a=%h expected v=1 a=%h", axi.arvalid, axi.araddr, p_ara);
        end
      end
      p_awv = axi.awvalid; p_awr = axi.awready; p_awa = axi.awaddr;
      p_wv  = axi.wvalid;  p_wr  = axi.wready;  p_wd  = axi.wdata; p_ws = axi.wstrb;
      p_arv = axi.arvalid; p_arr = axi.arready; p_ara = axi.araddr;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [4];
  logic [15:0] ref_err;

  task automatic ref_reset();
    for (int k = 0; k < 4; k++) ref_mem[k] = '0;
    ref_err = '0;
  endtask

  task automatic ref_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] er, output logic [1:0] eresp);
    int idx;
    idx = int'(a / 4) % 4;
    if (a < 32'h10) begin
      eresp = 2'b00;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        er = '0;
      end else begin
        er = ref_mem[idx];
      end
    end else begin
      er    = wr ? 32'h0 : 32'hDEAD_BEEF;
      eresp = wr ? 2'b10 : 2'b11;
    end
    if (eresp != 2'b00 && ref_err != 16'hFFFF) ref_err = ref_err + 16'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One command through to its response; hold = cycles rsp_ready stays low once rsp_valid rises.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int hold, input bit chk_lat);
    logic [31:0] er;
    logic [1:0]  eresp;
    int t;
    ref_txn(wr, a, d, s, er, eresp);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom; cmd_wstrb = 4'($urandom);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    // Always-ready slave: response visible in the 4th cycle counting the accept cycle.
    if (chk_lat) chk("latency", t, 32'd2);
    chk("rsp_is_write", 32'(rsp_is_write), 32'(wr));
    chk("rsp_rdata", rsp_rdata, er);
    chk("rsp_resp", 32'(rsp_resp), 32'(eresp));
    $display("[TB] %s addr=%h data=%h strb=%h -> rdata=%h resp=%0d",
             wr ? "WR" : "RD", a, d, s, rsp_rdata, rsp_resp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, er);
      chk("hold_resp", 32'(rsp_resp), 32'(eresp));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          r_wr;
  logic [31:0] r_a, r_d;
  logic [3:0]  r_s;
  int          r_t;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_valids", {28'd0, axi.awvalid, axi.wvalid, axi.arvalid, 1'b0}, 32'd0);
    chk("rst_readies", {30'd0, axi.bready, axi.rready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1/2: write then read back all four registers, always-ready slave
    mode = 0;
    for (int i = 0; i < 4; i++) txn(1'b1, 32'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF, 0, 1'b1);
    for (int i = 0; i < 4; i++) txn(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, 1'b1);
    chk("reg2_direct", ref_mem[2], 32'hA5A5_0002);

    // 3: unmapped read
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    // 4: awready trails wready by several cycles
    mode = 2;
    txn(1'b1, 32'h8, 32'h1234_5678, 4'h5, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("single_rsp", 32'(rsp_valid), 32'd0);
    end
    txn(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);

    // 5: response back-pressure
    mode = 0;
    txn(1'b0, 32'h0, 32'h0, 4'h0, 5, 1'b0);

    // randomized traffic against random slave timing
    mode = 1;
    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_a  = 32'($urandom_range(0, 9)) * 32'd4;
      r_d  = $urandom;
      r_s  = 4'($urandom);
      r_t  = $urandom_range(0, 2);
      txn(r_wr, r_a, r_d, r_s, r_t, 1'b0);
    end

    // 6: reset while the write is waiting for AW/W
    mode = 3;
    cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    r_t = 0;
    while (cmd_ready !== 1'b1 && r_t < 50) begin @(posedge clk); #1; r_t++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("wrreq_awvalid", 32'(axi.awvalid), 32'd1);
    chk("wrreq_wvalid", 32'(axi.wvalid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_awvalid", 32'(axi.awvalid), 32'd0);
    chk("async_wvalid", 32'(axi.wvalid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_cmd_ready", 32'(cmd_ready), 32'd0);
    $display("[TB] RST during WR_REQ -> awvalid=%b wvalid=%b busy=%b", axi.awvalid, axi.wvalid, busy);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_reset();
    mode = 0;
    @(posedge clk); #1;
    txn(1'b1, 32'h4, 32'h0BAD_F00D, 4'hF, 0, 1'b1);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1);

`ifdef AXIL_MST_ERRCNT_EN
    txn(1'b1, 32'h30, 32'h0, 4'hF, 0, 1'b0);
    chk("err_cnt", 32'(err_cnt), 32'(ref_err));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
